trap_sequencer: RTL and testbench

Sequences every architectural trap and MRET through the CSR file. Collects exception requests from fetch, decode, exec and mem, plus MRET from exec, and picks one by pipeline age. It then flushes and drains the pipeline, issues a single-cycle update strobe to the CSR file, and redirects fetch to mtvec or mepc. It sits beside the CSR block and owns the trap_* / xret_* update ports that the CSR file consumes.

---
 rtl/trap_sequencer.sv | 164 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - picks one trap or MRET by pipeline age, flushes, drains,
// strobes the CSR update and redirects fetch to mtvec or mepc.
module trap_sequencer #(
  parameter int XLEN         = 32,
  parameter int ALEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        exc_valid,
  input  logic [15:0]       exc_cause,
  input  logic [4*ALEN-1:0] exc_epc,
  input  logic [4*XLEN-1:0] exc_tval,
  input  logic              mret_valid,
  input  logic [ALEN-1:0]   mret_pc,
  input  logic              pipeline_drained,
  input  logic [1:0]        privilege_mode,
  input  logic [XLEN-1:0]   mstatus,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  output logic              busy,
  output logic              flush,
  output logic              trap_do_update,
  output logic [3:0]        trap_mcause,
  output logic [ALEN-1:0]   trap_mepc,
  output logic [XLEN-1:0]   trap_mtval,
  output logic              xret_do_update,
  output logic [XLEN-1:0]   xret_new_mstatus,
  output logic [1:0]        xret_new_privilege_mode,
  output logic              redirect_valid,
  output logic [ALEN-1:0]   redirect_pc,
  input  logic              redirect_ready
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  localparam logic [1:0] MACHINE       = 2'b11;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] FLUSH_LAST    = 4'(FLUSH_CYCLES - 1);

  state_t            state, state_next;
  logic              kind_xret;
  logic [3:0]        cause_q;
  logic [ALEN-1:0]   epc_q;
  logic [XLEN-1:0]   tval_q;
  logic [3:0]        flush_cnt;

  logic              sel_valid;
  logic              sel_xret;
  logic [3:0]        sel_cause;
  logic [ALEN-1:0]   sel_epc;
  logic [XLEN-1:0]   sel_tval;
  logic [XLEN-1:0]   mret_mstatus;
  logic [XLEN-1:0]   tvec_aligned;
  logic [ALEN-1:0]   commit_target;

  assign trap_mcause = cause_q;
  assign trap_mepc   = epc_q;
  assign trap_mtval  = tval_q;

  // Oldest instruction wins: mem, exec, MRET (sits in exec), decode, fetch.
  always_comb begin
    sel_valid = 1'b1;
    sel_xret  = 1'b0;
    sel_cause = '0;
    sel_epc   = '0;
    sel_tval  = '0;
    if (exc_valid[3]) begin
      sel_cause = exc_cause[15:12];
      sel_epc   = exc_epc[3*ALEN +: ALEN];
      sel_tval  = exc_tval[3*XLEN +: XLEN];
    end else if (exc_valid[2]) begin
      sel_cause = exc_cause[11:8];
      sel_epc   = exc_epc[2*ALEN +: ALEN];
      sel_tval  = exc_tval[2*XLEN +: XLEN];
    end else if (mret_valid) begin
      if (privilege_mode == MACHINE) begin
        sel_xret = 1'b1;
      end else begin
        sel_cause = CAUSE_ILLEGAL;
        sel_epc   = mret_pc;
      end
    end else if (exc_valid[1]) begin
      sel_cause = exc_cause[7:4];
      sel_epc   = exc_epc[1*ALEN +: ALEN];
      sel_tval  = exc_tval[1*XLEN +: XLEN];
    end else if (exc_valid[0]) begin
      sel_cause = exc_cause[3:0];
      sel_epc   = exc_epc[0 +: ALEN];
      sel_tval  = exc_tval[0 +: XLEN];
    end else begin
      sel_valid = 1'b0;
    end
  end

  always_comb begin
    mret_mstatus        = mstatus;
    mret_mstatus[3]     = mstatus[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b00;
    tvec_aligned        = mtvec & ~(XLEN'(3));
    commit_target       = kind_xret ? mepc[ALEN-1:0] : tvec_aligned[ALEN-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (sel_valid) state_next = DRAIN;
      DRAIN:    if (flush_cnt >= FLUSH_LAST && pipeline_drained) state_next = COMMIT;
      COMMIT:   state_next = REDIRECT;
      REDIRECT: if (redirect_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= IDLE;
      kind_xret               <= 1'b0;
      cause_q                 <= '0;
      epc_q                   <= '0;
      tval_q                  <= '0;
      flush_cnt               <= '0;
      busy                    <= 1'b0;
      flush                   <= 1'b0;
      trap_do_update          <= 1'b0;
      xret_do_update          <= 1'b0;
      xret_new_mstatus        <= '0;
      xret_new_privilege_mode <= '0;
      redirect_valid          <= 1'b0;
      redirect_pc             <= '0;
    end else begin
      state          <= state_next;
      busy           <= (state_next != IDLE);
      flush          <= (state_next == DRAIN);
      trap_do_update <= (state_next == COMMIT) && !kind_xret;
      xret_do_update <= (state_next == COMMIT) && kind_xret;
      redirect_valid <= (state_next == REDIRECT);

      if (state == IDLE && sel_valid) begin
        kind_xret <= sel_xret;
        cause_q   <= sel_cause;
        epc_q     <= sel_epc;
        tval_q    <= sel_tval;
        flush_cnt <= '0;
      end

      if (state == DRAIN && flush_cnt != 4'hF) begin
        flush_cnt <= flush_cnt + 4'd1;
      end

      if (state == DRAIN && state_next == COMMIT) begin
        xret_new_mstatus        <= mret_mstatus;
        xret_new_privilege_mode <= mstatus[12:11];
      end

      if (state == COMMIT) begin
        redirect_pc <= commit_target;
      end
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed scoreboard bench for trap_sequencer.
module tb_trap_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   exc_valid;
  logic [15:0]  exc_cause;
  logic [127:0] exc_epc;
  logic [127:0] exc_tval;
  logic         mret_valid;
  logic [31:0]  mret_pc;
  logic         pipeline_drained;
  logic [1:0]   privilege_mode;
  logic [31:0]  mstatus, mtvec, mepc;
  logic         busy, flush;
  logic         trap_do_update;
  logic [3:0]   trap_mcause;
  logic [31:0]  trap_mepc, trap_mtval;
  logic         xret_do_update;
  logic [31:0]  xret_new_mstatus;
  logic [1:0]   xret_new_privilege_mode;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         redirect_ready;

  trap_sequencer dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_epc(exc_epc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .mret_pc(mret_pc),
    .pipeline_drained(pipeline_drained), .privilege_mode(privilege_mode),
    .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
    .busy(busy), .flush(flush),
    .trap_do_update(trap_do_update), .trap_mcause(trap_mcause),
    .trap_mepc(trap_mepc), .trap_mtval(trap_mtval),
    .xret_do_update(xret_do_update), .xret_new_mstatus(xret_new_mstatus),
    .xret_new_privilege_mode(xret_new_privilege_mode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        xret;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] mst;
    logic [1:0]  priv;
  } upd_t;

  upd_t        upd_q[$];
  logic [31:0] redir_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_trap(logic [3:0] c, logic [31:0] epc, logic [31:0] tval, logic [31:0] pc);
    upd_t e;
    e.xret = 1'b0; e.cause = c; e.epc = epc; e.tval = tval; e.mst = '0; e.priv = '0;
    upd_q.push_back(e);
    redir_q.push_back(pc);
  endtask

  task automatic expect_xret(logic [31:0] mst, logic [1:0] priv, logic [31:0] pc);
    upd_t e;
    e.xret = 1'b1; e.cause = '0; e.epc = '0; e.tval = '0; e.mst = mst; e.priv = priv;
    upd_q.push_back(e);
    redir_q.push_back(pc);
  endtask

  task automatic set_exc(int src, logic [3:0] c, logic [31:0] epc, logic [31:0] tval);
    exc_valid[src]       = 1'b1;
    exc_cause[src*4 +: 4] = c;
    exc_epc[src*32 +: 32] = epc;
    exc_tval[src*32 +: 32] = tval;
  endtask

  task automatic clear_req();
    exc_valid  = '0;
    mret_valid = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Scoreboard: every strobe and redirect handshake consumes one queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (trap_do_update || xret_do_update) begin
        chk("strobe_exclusive", 32'(trap_do_update & xret_do_update), 32'd0);
        chk("strobe_vs_redirect", 32'(redirect_valid), 32'd0);
        if (upd_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          upd_t e;
          e = upd_q.pop_front();
          chk("kind_xret", 32'(xret_do_update), 32'(e.xret));
          if (!e.xret) begin
            chk("mcause", 32'(trap_mcause), 32'(e.cause));
            chk("mepc", trap_mepc, e.epc);
            chk("mtval", trap_mtval, e.tval);
          end else begin
            chk("new_mstatus", xret_new_mstatus, e.mst);
            chk("new_priv", 32'(xret_new_privilege_mode), 32'(e.priv));
          end
        end
      end
      if (redirect_valid && redirect_ready) begin
        if (redir_q.size() == 0) begin
          chk("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          chk("redirect_pc", redirect_pc, redir_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] held_pc;
    rst = 1'b0;
    exc_valid = '0; exc_cause = '0; exc_epc = '0; exc_tval = '0;
    mret_valid = 1'b0; mret_pc = '0;
    pipeline_drained = 1'b1; privilege_mode = 2'b11;
    mstatus = '0; mtvec = 32'h8000_0101; mepc = '0;
    redirect_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctl", 32'({flush, trap_do_update, xret_do_update, redirect_valid}), 32'd0);
    chk("rst_data", trap_mepc | trap_mtval | redirect_pc | xret_new_mstatus, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Mem load fault, cycle-accurate timeline.
    @(posedge clk); #1;
    set_exc(3, 4'd5, 32'h8000_0010, 32'h0000_DEAD);
    expect_trap(4'd5, 32'h8000_0010, 32'h0000_DEAD, 32'h8000_0100);
    @(posedge clk); #1 clear_req();
    @(negedge clk);
    chk("c1_flush", 32'(flush), 32'd1);
    chk("c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("c2_flush", 32'(flush), 32'd1);
    chk("c2_no_update", 32'(trap_do_update), 32'd0);
    @(negedge clk);
    chk("c3_update", 32'(trap_do_update), 32'd1);
    chk("c3_flush", 32'(flush), 32'd0);
    @(negedge clk);
    chk("c4_redirect", 32'(redirect_valid), 32'd1);
    @(negedge clk);
    chk("c5_idle", 32'(busy), 32'd0);
    chk("c5_no_redirect", 32'(redirect_valid), 32'd0);

    // Fetch + exec + MRET: exec is oldest.
    @(posedge clk); #1;
    set_exc(0, 4'd1, 32'h0000_1000, 32'h1);
    set_exc(2, 4'd2, 32'h0000_2000, 32'h2);
    mret_valid = 1'b1; mret_pc = 32'h0000_3000;
    expect_trap(4'd2, 32'h0000_2000, 32'h2, 32'h8000_0100);
    @(posedge clk); #1 clear_req();
    wait_idle("prio_exec_idle");

    // Fetch + mem: mem wins.
    @(posedge clk); #1;
    set_exc(0, 4'd1, 32'h0000_1000, 32'h1);
    set_exc(3, 4'd7, 32'h0000_4000, 32'h44);
    expect_trap(4'd7, 32'h0000_4000, 32'h44, 32'h8000_0100);
    @(posedge clk); #1 clear_req();
    wait_idle("prio_mem_idle");

    // MRET in machine mode.
    @(posedge clk); #1;
    mstatus = 32'h0000_1880; mepc = 32'h8000_0200; privilege_mode = 2'b11;
    mret_valid = 1'b1; mret_pc = 32'h0000_5000;
    expect_xret(32'h0000_0088, 2'b11, 32'h8000_0200);
    @(posedge clk); #1 clear_req();
    wait_idle("mret_m_idle");

    // MRET from user mode is an illegal instruction.
    @(posedge clk); #1;
    privilege_mode = 2'b00;
    mret_valid = 1'b1; mret_pc = 32'h0000_0400;
    expect_trap(4'd2, 32'h0000_0400, 32'h0, 32'h8000_0100);
    @(posedge clk); #1 clear_req();
    wait_idle("mret_u_idle");
    privilege_mode = 2'b11;

    // Slow drain and slow fetch.
    @(posedge clk); #1;
    pipeline_drained = 1'b0; redirect_ready = 1'b0;
    set_exc(1, 4'd3, 32'h0000_6000, 32'h66);
    expect_trap(4'd3, 32'h0000_6000, 32'h66, 32'h8000_0100);
    @(posedge clk); #1 clear_req();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_flush", 32'(flush), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 pipeline_drained = 1'b1;
    @(negedge clk);
    chk("drain_rise_no_update", 32'(trap_do_update), 32'd0);
    @(negedge clk);
    chk("commit_after_drain", 32'(trap_do_update), 32'd1);
    @(negedge clk);
    held_pc = redirect_pc;
    chk("wait_pc", held_pc, 32'h8000_0100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wait_valid", 32'(redirect_valid), 32'd1);
      chk("wait_pc_stable", redirect_pc, held_pc);
      chk("wait_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 redirect_ready = 1'b1;
    wait_idle("slow_idle");

    // Reset in the middle of DRAIN.
    @(posedge clk); #1;
    pipeline_drained = 1'b0;
    set_exc(3, 4'd4, 32'h0000_7000, 32'h77);
    @(posedge clk); #1 clear_req();
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({busy, flush, trap_do_update, xret_do_update, redirect_valid}), 32'd0);
    chk("async_rst_data", trap_mepc | trap_mtval | redirect_pc | xret_new_mstatus, 32'd0);
    @(posedge clk); #1 rst = 1'b1; pipeline_drained = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({busy, trap_do_update, xret_do_update, redirect_valid}), 32'd0);
    end

    chk("upd_q_empty", 32'(upd_q.size()), 32'd0);
    chk("redir_q_empty", 32'(redir_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
